bitty_fetch_unit: RTL and testbench
===================================

# bitty_fetch_unit

Instruction-supply stage placed directly upstream of `bitty_core`. It holds a small writable program memory and a program counter, and fetches one 16-bit instruction at a time. It presents each instruction to the core with `run` asserted, then waits for the core's `done` pulse before advancing. Execution stops at a halt instruction, which is never issued to the core.

## Interface
- `ADDR_W`, default 8: program memory address width; depth is 2^ADDR_W words.
- `HALT_INSTR`, default 16'h0000: instruction encoding that stops fetching.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  reset; asynchronous, active-high.
- `load_en`  in  1  program-memory write strobe; honoured only in IDLE or HALT.
- `load_addr`  in  ADDR_W  write address.
- `load_data`  in  16  write data.
- `start`  in  1  begin execution at `start_addr`; honoured only in IDLE or HALT.
- `start_addr`  in  ADDR_W  first PC value.
- `done`  in  1  core completion pulse; sampled only in ISSUE.
- `instruction`  out  16  registered instruction driven to the core.
- `run`  out  1  high exactly while in ISSUE.
- `pc`  out  ADDR_W  address of the current/next instruction.
- `busy`  out  1  high in FETCH or ISSUE.
- `halted`  out  1  high in HALT.
- `retired`  out  16  count of instructions the core has accepted `done` for; wraps at 2^16.

## Operation
- Memory: 2^ADDR_W x 16 with a synchronous write port and a synchronous read port. Contents are not reset.
- FSM states: IDLE, FETCH, ISSUE, HALT. All registers are cleared by reset; the state returns to IDLE.
- IDLE / HALT:
  - `load_en` writes `load_data` to `mem[load_addr]` at the clock edge.
  - `start` sets `pc <= start_addr`, clears `retired`, and moves to FETCH.
  - If `load_en` and `start` occur in the same cycle, both act. A write to `start_addr` is visible to the first fetch.
- FETCH, one cycle: `instruction <= mem[pc]`.
  - If the fetched word equals HALT_INSTR, go to HALT. `pc` is unchanged and `run` is never raised for that word.
  - Otherwise go to ISSUE.
- ISSUE: `run = 1` and `instruction` is held stable.
  - When `done` is sampled high: `pc <= pc + 1` (modulo 2^ADDR_W, so the last address wraps to 0), `retired <= retired + 1`, and the state moves to FETCH.
- Ignored inputs:
  - `done` is ignored outside ISSUE.
  - `start` and `load_en` are ignored in FETCH and ISSUE. The memory is not modified while executing.
- Reset mid-operation: `run`, `busy` and `halted` drop asynchronously; `pc`, `instruction` and `retired` become 0.

## Timing
- Reset values: `instruction` = 0, `run` = 0, `pc` = 0, `busy` = 0, `halted` = 0, `retired` = 0, state IDLE.
- `start` sampled at edge N: FETCH during cycle N..N+1, and `run` = 1 from edge N+1.
- `done` sampled at edge M: `run` = 0 after M (FETCH cycle), and the next `run` rises at edge M+1. The per-instruction overhead is one FETCH cycle.
- A `done` held high for several cycles counts once per ISSUE entry. A new `done` is only recognised after `run` has re-risen.
- Halt detection: HALT_INSTR fetched in the FETCH cycle ending at edge K gives `halted` = 1 from K. `busy` and `run` stay 0 after that.
- All outputs are registered or decoded from registered state. There are no combinational paths from inputs to outputs.

## Test plan
- Reset in the middle of ISSUE (`run` = 1) → `run` = 0 immediately with no clock; `pc` = 0, `retired` = 0, state IDLE; after release, `start` works normally.
- Load `mem[0..2]` = 16'h2A48, 16'h4C50, 16'h0000; `start` with `start_addr` = 0; answer each `run` with a 1-cycle `done` 3 cycles later → `instruction` shows 16'h2A48 then 16'h4C50; `halted` = 1 with `pc` = 2 and `retired` = 2; `run` is never high with 16'h0000.
- Set `ADDR_W` = 2, fill `mem[3]` = 16'h1111 and `mem[0]` = HALT_INSTR, `start_addr` = 3; complete one `done` → `pc` wraps 3→0, then `halted` = 1, `retired` = 1.
- Same cycle `load_en`(addr 5, 16'hBEEF) and `start`(5) in IDLE → the first issued `instruction` = 16'hBEEF.
- During ISSUE, pulse `load_en`(addr 0, 16'hFFFF) and `start`, and assert `done` while in FETCH → memory unchanged, `pc` unchanged, and the stray `done` is not counted.
- Hold `done` = 1 continuously over 4 instructions → each instruction is issued for exactly 1 cycle, `retired` increments by exactly 1 per instruction, and there is 1 FETCH cycle between issues.

Source files
------------

// File: rtl/bitty_fetch_unit_if.sv
// Fetch-unit bus: program loading, start control, core handshake and status.
// The master side (loader/core) drives the strobes; the slave side is the fetch unit.
interface bitty_fetch_if #(
    parameter int unsigned ADDR_W = 8
);
    logic              load_en;
    logic [ADDR_W-1:0] load_addr;
    logic [15:0]       load_data;
    logic              start;
    logic [ADDR_W-1:0] start_addr;
    logic              done;
    logic [15:0]       instruction;
    logic              run;
    logic [ADDR_W-1:0] pc;
    logic              busy;
    logic              halted;
    logic [15:0]       retired;

    modport master (
        output load_en, load_addr, load_data, start, start_addr, done,
        input  instruction, run, pc, busy, halted, retired
    );

    modport slave (
        input  load_en, load_addr, load_data, start, start_addr, done,
        output instruction, run, pc, busy, halted, retired
    );
endinterface

// File: rtl/bitty_fetch_unit.sv
// Instruction-supply stage for bitty_core: program memory, PC, and run/done sequencing.
// Fetches one word per instruction and stops on HALT_INSTR without issuing it.
module bitty_fetch_unit #(
    parameter int unsigned ADDR_W     = 8,
    parameter logic [15:0] HALT_INSTR = 16'h0000
) (
    input  logic        clk,
    input  logic        reset,
    bitty_fetch_if.slave bus
);
    localparam int unsigned DATA_W = 16;
    localparam int unsigned DEPTH  = 1 << ADDR_W;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_ISSUE = 2'd2;
    localparam logic [1:0] S_HALT  = 2'd3;

    logic [DATA_W-1:0] mem [DEPTH];

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] instr_q, instr_d;
    logic [15:0]       retired_q, retired_d;
    logic              run_q, run_d;
    logic              busy_q, busy_d;
    logic              halted_q, halted_d;
    logic              mem_we;
    logic [DATA_W-1:0] fetch_word;

    // Read data is captured into instr_q at the end of FETCH, so a write in the
    // start cycle is already visible to the first fetch.
    assign fetch_word = mem[pc_q];

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        instr_d   = instr_q;
        retired_d = retired_q;
        mem_we    = 1'b0;

        case (state_q)
            S_IDLE, S_HALT: begin
                mem_we = bus.load_en;
                if (bus.start) begin
                    pc_d      = bus.start_addr;
                    retired_d = 16'd0;
                    state_d   = S_FETCH;
                end
            end
            S_FETCH: begin
                instr_d = fetch_word;
                state_d = (fetch_word == HALT_INSTR) ? S_HALT : S_ISSUE;
            end
            S_ISSUE: begin
                if (bus.done) begin
                    pc_d      = pc_q + ADDR_W'(1);
                    retired_d = retired_q + 16'd1;
                    state_d   = S_FETCH;
                end
            end
            default: state_d = S_IDLE;
        endcase

        run_d    = (state_d == S_ISSUE);
        busy_d   = (state_d == S_FETCH) || (state_d == S_ISSUE);
        halted_d = (state_d == S_HALT);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            pc_q      <= '0;
            instr_q   <= '0;
            retired_q <= '0;
            run_q     <= 1'b0;
            busy_q    <= 1'b0;
            halted_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            instr_q   <= instr_d;
            retired_q <= retired_d;
            run_q     <= run_d;
            busy_q    <= busy_d;
            halted_q  <= halted_d;
        end
    end

    // Program memory contents survive reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[bus.load_addr] <= bus.load_data;
        end
    end

    assign bus.instruction = instr_q;
    assign bus.run         = run_q;
    assign bus.pc          = pc_q;
    assign bus.busy        = busy_q;
    assign bus.halted      = halted_q;
    assign bus.retired     = retired_q;
endmodule

// File: tb/tb_bitty_fetch_unit.sv
// Directed self-checking bench for bitty_fetch_unit (ADDR_W=8 and ADDR_W=2 instances).
module tb_bitty_fetch_unit;
    logic clk;
    logic reset;
    int   checks;
    int   errors;

    bitty_fetch_if #(.ADDR_W(8)) bus_a ();
    bitty_fetch_if #(.ADDR_W(2)) bus_b ();

    bitty_fetch_unit #(.ADDR_W(8), .HALT_INSTR(16'h0000)) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_a)
    );

    bitty_fetch_unit #(.ADDR_W(2), .HALT_INSTR(16'h0000)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_a(input logic [7:0] addr, input logic [15:0] data);
        bus_a.load_en   = 1'b1;
        bus_a.load_addr = addr;
        bus_a.load_data = data;
        tick();
        bus_a.load_en   = 1'b0;
    endtask

    task automatic start_a(input logic [7:0] addr);
        bus_a.start      = 1'b1;
        bus_a.start_addr = addr;
        tick();
        bus_a.start      = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        {bus_a.load_en, bus_a.load_addr, bus_a.load_data} = '0;
        {bus_a.start, bus_a.start_addr, bus_a.done}       = '0;
        {bus_b.load_en, bus_b.load_addr, bus_b.load_data} = '0;
        {bus_b.start, bus_b.start_addr, bus_b.done}       = '0;

        #12;
        chk("rst_instr",   32'(bus_a.instruction), 32'h0);
        chk("rst_run",     32'(bus_a.run),         32'h0);
        chk("rst_pc",      32'(bus_a.pc),          32'h0);
        chk("rst_busy",    32'(bus_a.busy),        32'h0);
        chk("rst_halted",  32'(bus_a.halted),      32'h0);
        chk("rst_retired", 32'(bus_a.retired),     32'h0);
        @(negedge clk);
        reset = 1'b0;

        // Basic program: two instructions then halt
        load_a(8'd0, 16'h2A48);
        load_a(8'd1, 16'h4C50);
        load_a(8'd2, 16'h0000);
        start_a(8'd0);
        chk("p_fetch_busy", 32'(bus_a.busy), 32'h1);
        chk("p_fetch_run",  32'(bus_a.run),  32'h0);
        tick();
        chk("p_i0_run",   32'(bus_a.run),         32'h1);
        chk("p_i0_instr", 32'(bus_a.instruction), 32'h2A48);
        chk("p_i0_pc",    32'(bus_a.pc),          32'h0);
        tick();
        tick();
        chk("p_i0_hold", 32'(bus_a.instruction), 32'h2A48);
        bus_a.done = 1'b1;
        tick();
        bus_a.done = 1'b0;
        chk("p_d0_run",     32'(bus_a.run),     32'h0);
        chk("p_d0_pc",      32'(bus_a.pc),      32'h1);
        chk("p_d0_retired", 32'(bus_a.retired), 32'h1);
        tick();
        chk("p_i1_run",   32'(bus_a.run),         32'h1);
        chk("p_i1_instr", 32'(bus_a.instruction), 32'h4C50);
        tick();
        tick();
        bus_a.done = 1'b1;
        tick();
        bus_a.done = 1'b0;
        chk("p_d1_retired", 32'(bus_a.retired), 32'h2);
        tick();
        chk("p_halted",  32'(bus_a.halted),  32'h1);
        chk("p_h_run",   32'(bus_a.run),     32'h0);
        chk("p_h_busy",  32'(bus_a.busy),    32'h0);
        chk("p_h_pc",    32'(bus_a.pc),      32'h2);
        chk("p_h_ret",   32'(bus_a.retired), 32'h2);
        tick();
        chk("p_h_run2",  32'(bus_a.run),     32'h0);

        // Asynchronous reset while in ISSUE
        start_a(8'd0);
        chk("r_start_clr_ret", 32'(bus_a.retired), 32'h0);
        tick();
        chk("r_pre_run", 32'(bus_a.run), 32'h1);
        #2 reset = 1'b1;
        #1;
        chk("r_run",    32'(bus_a.run),     32'h0);
        chk("r_busy",   32'(bus_a.busy),    32'h0);
        chk("r_pc",     32'(bus_a.pc),      32'h0);
        chk("r_instr",  32'(bus_a.instruction), 32'h0);
        #2 reset = 1'b0;
        start_a(8'd0);
        tick();
        chk("r_after_run",   32'(bus_a.run),         32'h1);
        chk("r_after_instr", 32'(bus_a.instruction), 32'h2A48);

        // Load/start during ISSUE and done during FETCH are ignored
        bus_a.load_en   = 1'b1;
        bus_a.load_addr = 8'd0;
        bus_a.load_data = 16'hFFFF;
        bus_a.start      = 1'b1;
        bus_a.start_addr = 8'd2;
        tick();
        bus_a.load_en = 1'b0;
        bus_a.start   = 1'b0;
        chk("ig_run", 32'(bus_a.run), 32'h1);
        chk("ig_pc",  32'(bus_a.pc),  32'h0);
        bus_a.done = 1'b1;
        tick();
        chk("ig_fetch_run", 32'(bus_a.run),     32'h0);
        chk("ig_ret1",      32'(bus_a.retired), 32'h1);
        tick();
        bus_a.done = 1'b0;
        chk("ig_i1_run",   32'(bus_a.run),         32'h1);
        chk("ig_i1_pc",    32'(bus_a.pc),          32'h1);
        chk("ig_i1_ret",   32'(bus_a.retired),     32'h1);
        chk("ig_i1_instr", 32'(bus_a.instruction), 32'h4C50);
        bus_a.done = 1'b1;
        tick();
        bus_a.done = 1'b0;
        tick();
        chk("ig_halted", 32'(bus_a.halted),  32'h1);
        chk("ig_ret2",   32'(bus_a.retired), 32'h2);
        start_a(8'd0);
        tick();
        chk("ig_mem0", 32'(bus_a.instruction), 32'h2A48);

        // Same-cycle load and start: the fresh word is fetched
        #2 reset = 1'b1;
        #2 reset = 1'b0;
        load_a(8'd6, 16'h0000);
        bus_a.load_en    = 1'b1;
        bus_a.load_addr  = 8'd5;
        bus_a.load_data  = 16'hBEEF;
        bus_a.start      = 1'b1;
        bus_a.start_addr = 8'd5;
        tick();
        bus_a.load_en = 1'b0;
        bus_a.start   = 1'b0;
        tick();
        chk("lc_run",   32'(bus_a.run),         32'h1);
        chk("lc_instr", 32'(bus_a.instruction), 32'hBEEF);
        chk("lc_pc",    32'(bus_a.pc),          32'h5);
        bus_a.done = 1'b1;
        tick();
        bus_a.done = 1'b0;
        tick();
        chk("lc_halted", 32'(bus_a.halted), 32'h1);

        // done held high across four instructions
        load_a(8'd10, 16'h0001);
        load_a(8'd11, 16'h0002);
        load_a(8'd12, 16'h0003);
        load_a(8'd13, 16'h0004);
        load_a(8'd14, 16'h0000);
        bus_a.done = 1'b1;
        start_a(8'd10);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("hd_run1",  32'(bus_a.run),         32'h1);
            chk("hd_instr", 32'(bus_a.instruction), 32'(i + 1));
            chk("hd_ret_a", 32'(bus_a.retired),     32'(i));
            tick();
            chk("hd_run0",  32'(bus_a.run),     32'h0);
            chk("hd_busy",  32'(bus_a.busy),    32'h1);
            chk("hd_ret_b", 32'(bus_a.retired), 32'(i + 1));
            chk("hd_pc",    32'(bus_a.pc),      32'(11 + i));
        end
        tick();
        bus_a.done = 1'b0;
        chk("hd_halted", 32'(bus_a.halted),  32'h1);
        chk("hd_ret",    32'(bus_a.retired), 32'h4);

        // PC wrap on the 2-bit instance
        bus_b.load_en   = 1'b1;
        bus_b.load_addr = 2'd3;
        bus_b.load_data = 16'h1111;
        tick();
        bus_b.load_addr = 2'd0;
        bus_b.load_data = 16'h0000;
        tick();
        bus_b.load_en    = 1'b0;
        bus_b.start      = 1'b1;
        bus_b.start_addr = 2'd3;
        tick();
        bus_b.start = 1'b0;
        tick();
        chk("w_run",   32'(bus_b.run),         32'h1);
        chk("w_instr", 32'(bus_b.instruction), 32'h1111);
        chk("w_pc3",   32'(bus_b.pc),          32'h3);
        bus_b.done = 1'b1;
        tick();
        bus_b.done = 1'b0;
        chk("w_pc0", 32'(bus_b.pc), 32'h0);
        tick();
        chk("w_halted",  32'(bus_b.halted),  32'h1);
        chk("w_retired", 32'(bus_b.retired), 32'h1);
        chk("w_pc_h",    32'(bus_b.pc),      32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
